// File: rtl/imm_ctrl.sv
// Two-entry immediate-decode controller: stage A drives the immediate picker, stage B registers the result.
// Optional illegal-opcode detection is enabled by defining IMM_CTRL_ILLEGAL_CHECK_EN.
module imm_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTRUCTION,
  input  logic        FLUSH,
  output logic [2:0]  IMM_PICK,
  output logic [31:0] PICK_INSTR,
  input  logic [31:0] IMM_IN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] IMMEDIATE,
  output logic [31:0] OUT_INSTR,
  output logic        ILLEGAL
);

  typedef enum logic [2:0] {
    PICK_I = 3'b000,
    PICK_S = 3'b001,
    PICK_U = 3'b010,
    PICK_B = 3'b011,
    PICK_J = 3'b100
  } pick_e;

  logic        a_valid_q, a_valid_d;
  logic [31:0] a_instr_q;
  logic        b_valid_q, b_valid_d;
  logic [31:0] b_imm_q;
  logic [31:0] b_instr_q;
  logic        b_ill_q;

  logic        advance_a;
  logic        accept;
  logic        load_b;
  pick_e       pick;
  logic        zero_imm;
  logic        dec_illegal;
  logic [31:0] imm_sel;

  always_comb begin
    pick        = PICK_I;
    zero_imm    = 1'b0;
    dec_illegal = 1'b0;
    case (a_instr_q[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: pick = PICK_I;
      7'b0100011:                                     pick = PICK_S;
      7'b0110111, 7'b0010111:                         pick = PICK_U;
      7'b1100011:                                     pick = PICK_B;
      7'b1101111:                                     pick = PICK_J;
      7'b0110011: begin
        pick     = PICK_I;
        zero_imm = 1'b1;
      end
      default: begin
        pick = PICK_I;
`ifdef IMM_CTRL_ILLEGAL_CHECK_EN
        dec_illegal = 1'b1;
        zero_imm    = 1'b1;
`endif
      end
    endcase
  end

  assign imm_sel = zero_imm ? '0 : IMM_IN;

  assign advance_a = a_valid_q && (!b_valid_q || OUT_READY);
  assign IN_READY  = FLUSH || !a_valid_q || advance_a;
  assign accept    = IN_VALID && IN_READY && !FLUSH;
  assign load_b    = advance_a && !FLUSH;

  // Later assignments win: FLUSH overrides every handshake in the same cycle.
  always_comb begin
    a_valid_d = a_valid_q;
    if (advance_a) a_valid_d = 1'b0;
    if (accept)    a_valid_d = 1'b1;
    if (FLUSH)     a_valid_d = 1'b0;

    b_valid_d = b_valid_q;
    if (b_valid_q && OUT_READY) b_valid_d = 1'b0;
    if (advance_a)              b_valid_d = 1'b1;
    if (FLUSH)                  b_valid_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_valid_q <= 1'b0;
      a_instr_q <= '0;
      b_valid_q <= 1'b0;
      b_imm_q   <= '0;
      b_instr_q <= '0;
      b_ill_q   <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      if (accept) a_instr_q <= INSTRUCTION;
      if (load_b) begin
        b_imm_q   <= imm_sel;
        b_instr_q <= a_instr_q;
        b_ill_q   <= dec_illegal;
      end
    end
  end

  assign IMM_PICK   = pick;
  assign PICK_INSTR = a_instr_q;
  assign OUT_VALID  = b_valid_q;
  assign IMMEDIATE  = b_imm_q;
  assign OUT_INSTR  = b_instr_q;
  assign ILLEGAL    = b_ill_q;

endmodule

// File: doc/imm_ctrl.md
IMM_CTRL -- requirements
Module: imm_ctrl

Interface
REQ-001 The module SHALL have no parameters; all widths SHALL be fixed: instruction 32, IMM_PICK 3, immediate 32.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 IN_VALID  input  1  fetch stage presents INSTRUCTION.
REQ-005 IN_READY  output  1  controller accepts INSTRUCTION this cycle.
REQ-006 INSTRUCTION  input  32  raw RV32IM instruction word.
REQ-007 FLUSH  input  1  squash all in-flight entries (branch redirect).
REQ-008 IMM_PICK  output  3  select to the immediate picker: 000 I, 001 S, 010 U, 011 B, 100 J.
REQ-009 PICK_INSTR  output  32  instruction word driven to the picker's INSTRUCTION input.
REQ-010 IMM_IN  input  32  immediate returned combinationally by the picker.
REQ-011 OUT_VALID  output  1  IMMEDIATE, OUT_INSTR and ILLEGAL are valid.
REQ-012 OUT_READY  input  1  execute stage consumes the output entry.
REQ-013 IMMEDIATE  output  32  registered immediate.
REQ-014 OUT_INSTR  output  32  registered instruction matching IMMEDIATE.
REQ-015 ILLEGAL  output  1  opcode not in the decode table.

Function
REQ-016 The controller SHALL be a two-entry pipeline: stage A (decode register) and stage B (output register), each holding a valid bit.
REQ-017 Input handshake: an instruction SHALL be accepted when IN_VALID && IN_READY; IN_READY = !A_valid || advance_A.
REQ-018 advance_A SHALL equal A_valid && (!B_valid || OUT_READY); output handshake completes when OUT_VALID && OUT_READY.
REQ-019 PICK_INSTR SHALL equal the stage-A instruction; IMM_PICK SHALL be decoded combinationally from stage-A opcode bits [6:0].
REQ-020 Decode table: 0010011, 0000011, 1100111, 1110011 -> 000; 0100011 -> 001; 0110111, 0010111 -> 010; 1100011 -> 011; 1101111 -> 100.
REQ-021 Opcode 0110011 (R-type, incl. M-extension) SHALL select 000, and stage B SHALL load IMMEDIATE = 0.
REQ-022 On advance_A, stage B SHALL load IMMEDIATE = IMM_IN (or 0 per REQ-021), OUT_INSTR = stage-A instruction, ILLEGAL = decode result.
REQ-023 Latency: an instruction accepted at edge N SHALL appear with OUT_VALID=1 after edge N+1 when unstalled; throughput SHALL be one per cycle.
REQ-024 Stall: with OUT_READY=0, stage B SHALL hold its contents unchanged; stage A SHALL fill, then IN_READY SHALL drop to 0.
REQ-025 Order SHALL be preserved; no entry SHALL be dropped or duplicated unless FLUSH is asserted.
REQ-026 FLUSH SHALL clear A_valid and B_valid at the next edge; an input presented in the same cycle SHALL be discarded; IN_READY SHALL read 1 during FLUSH.
REQ-027 FLUSH SHALL take priority over simultaneous accept, advance and output handshake.
REQ-028 Data registers SHALL update only on load; invalid entries SHALL hold stale data.

Reset
REQ-029 On RESET, A_valid, B_valid, OUT_VALID, ILLEGAL SHALL be 0; IMMEDIATE, OUT_INSTR and the stage-A instruction SHALL be 0x00000000.
REQ-030 IMM_PICK SHALL read 000 and IN_READY SHALL read 1 in the first cycle after reset.
REQ-031 RESET SHALL take priority over FLUSH and all handshakes; mid-stream reset SHALL discard all in-flight entries.

Configuration
REQ-032 Macro IMM_CTRL_ILLEGAL_CHECK_EN: when defined, opcodes outside REQ-020/021 SHALL set ILLEGAL=1, IMM_PICK=000, and IMMEDIATE=0.
REQ-033 When undefined, ILLEGAL SHALL be tied 0 and unknown opcodes SHALL be treated as I-type (IMMEDIATE=IMM_IN).

Verification
REQ-034 addi 0xFFF00093, OUT_READY=1 -> IMM_PICK=000 one cycle after accept; IMMEDIATE=0xFFFFFFFF with OUT_VALID=1 the following cycle.
REQ-035 Back-to-back lui 0x123450B7, sw 0xFE112E23, jal 0x0080006F -> IMMEDIATE 0x12345000, 0xFFFFFFFC, 0x00000008 on consecutive cycles.
REQ-036 OUT_READY=0 while 3 instructions are offered -> 2 held, IN_READY=0 on the third; after release, all 3 emerge in order unchanged.
REQ-037 FLUSH asserted with both stages valid and IN_VALID=1 -> OUT_VALID=0 next cycle; no flushed word ever appears at OUT_INSTR.
REQ-038 Opcode 0x0000007F with the macro defined -> ILLEGAL=1, IMMEDIATE=0; without it -> ILLEGAL=0, IMMEDIATE=IMM_IN.
REQ-039 RESET asserted mid-stream with stage B stalled -> all outputs reach REQ-029 values next cycle and IN_READY=1.
